pipe_ctrl_hazard_unit: RTL and testbench

Next-generation control for the 5-stage MIPS pipeline. It keeps the ID-stage instruction decode and adds registered control bundles for the EX, MEM and WB stages. It also adds load-use and branch hazard detection, EX operand forwarding selects, and a parametrised multi-cycle mult/div interlock. It sits beside the datapath and drives every stage's mux and write-enable controls.

---
 rtl/pipe_ctrl_hazard_unit_pkg.sv | 138 +++++++++++++
 rtl/pipe_ctrl_hazard_unit_decode.sv | 148 ++++++++++++++
 rtl/pipe_ctrl_hazard_unit.sv | 163 ++++++++++++++++
 tb/tb_pipe_ctrl_hazard_unit.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_hazard_unit_pkg.sv
// Shared encodings for the pipeline controller: ISA opcode/func constants,
// per-stage control bundle layouts and the bubble values.
package pipe_ctrl_hazard_unit_pkg;

    // Primary opcodes
    localparam logic [5:0] OP_RTYPE  = 6'h00;
    localparam logic [5:0] OP_REGIMM = 6'h01;
    localparam logic [5:0] OP_J      = 6'h02;
    localparam logic [5:0] OP_JAL    = 6'h03;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_BNE    = 6'h05;
    localparam logic [5:0] OP_BLEZ   = 6'h06;
    localparam logic [5:0] OP_BGTZ   = 6'h07;
    localparam logic [5:0] OP_ADDI   = 6'h08;
    localparam logic [5:0] OP_ADDIU  = 6'h09;
    localparam logic [5:0] OP_SLTI   = 6'h0A;
    localparam logic [5:0] OP_SLTIU  = 6'h0B;
    localparam logic [5:0] OP_ANDI   = 6'h0C;
    localparam logic [5:0] OP_ORI    = 6'h0D;
    localparam logic [5:0] OP_XORI   = 6'h0E;
    localparam logic [5:0] OP_LUI    = 6'h0F;
    localparam logic [5:0] OP_LB     = 6'h20;
    localparam logic [5:0] OP_LW     = 6'h23;
    localparam logic [5:0] OP_LBU    = 6'h24;
    localparam logic [5:0] OP_SB     = 6'h28;
    localparam logic [5:0] OP_SW     = 6'h2B;

    // R-type function codes
    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_SRL   = 6'h02;
    localparam logic [5:0] FN_SRA   = 6'h03;
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_JALR  = 6'h09;
    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1A;
    localparam logic [5:0] FN_DIVU  = 6'h1B;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_XOR   = 6'h26;
    localparam logic [5:0] FN_NOR   = 6'h27;
    localparam logic [5:0] FN_SLT   = 6'h2A;
    localparam logic [5:0] FN_SLTU  = 6'h2B;

    // REGIMM rt selectors
    localparam logic [4:0] RT_BLTZ = 5'd0;
    localparam logic [4:0] RT_BGEZ = 5'd1;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,  ALU_SUB  = 4'd1,  ALU_AND  = 4'd2,  ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,  ALU_NOR  = 4'd5,  ALU_SLT  = 4'd6,  ALU_SLTU = 4'd7,
        ALU_SLL  = 4'd8,  ALU_SRL  = 4'd9,  ALU_SRA  = 4'd10, ALU_LUI  = 4'd11,
        ALU_HI   = 4'd12, ALU_LO   = 4'd13, ALU_MULT = 4'd14, ALU_DIV  = 4'd15
    } alu_op_e;

    typedef enum logic [1:0] {LD_NONE = 2'd0, LD_W = 2'd1, LD_B = 2'd2, LD_BU = 2'd3} load_e;
    typedef enum logic [1:0] {ST_NONE = 2'd0, ST_W = 2'd1, ST_B = 2'd2} store_e;
    typedef enum logic [1:0] {MTR_ALU = 2'd0, MTR_MEM = 2'd1, MTR_LINK = 2'd2, MTR_HILO = 2'd3} mtr_e;

    typedef enum logic [3:0] {
        BR_NONE = 4'd0, BR_BEQ  = 4'd1, BR_BNE  = 4'd2, BR_BLEZ = 4'd3,
        BR_BGTZ = 4'd4, BR_BLTZ = 4'd5, BR_BGEZ = 4'd6, BR_J    = 4'd7,
        BR_JR   = 4'd8
    } br_kind_e;

    // EX bundle: [7:4] ALUOp, [3] ALUSrc_A (shamt), [2] ALUSrc_B (imm), [1] ExtSel (signed), [0] muldiv
    localparam int EX_MULDIV_BIT = 0;
    localparam int EX_EXT_BIT    = 1;
    localparam int EX_SRCB_BIT   = 2;
    localparam int EX_SRCA_BIT   = 3;
    localparam int EX_ALUOP_LSB  = 4;
    localparam int EX_W          = 8;

    // MEM bundle: [5:4] Store, [3:2] Load, [1] memWt, [0] memRd
    localparam int MEM_RD_BIT = 0;
    localparam int MEM_WT_BIT = 1;
    localparam int MEM_LD_LSB = 2;
    localparam int MEM_ST_LSB = 4;
    localparam int MEM_W      = 6;

    // WB bundle: [2:1] MemtoReg, [0] RegWre
    localparam int WB_REGWRE_BIT = 0;
    localparam int WB_MTR_LSB    = 1;
    localparam int WB_W          = 3;

    localparam logic [EX_W-1:0]  EX_BUBBLE  = '0;
    localparam logic [MEM_W-1:0] MEM_BUBBLE = '0;
    localparam logic [WB_W-1:0]  WB_BUBBLE  = '0;

    typedef struct packed {
        logic [EX_W-1:0]  ex;
        logic [MEM_W-1:0] mem;
        logic [WB_W-1:0]  wb;
        logic             reads_rs;
        logic             reads_rt;
        br_kind_e         br;
        logic             hilo;      // touches HI/LO: mfhi/mflo/mult/div
    } dec_t;

    localparam dec_t DEC_BUBBLE = '0;

    function automatic logic [EX_W-1:0] ex_pack(input alu_op_e op, input logic src_a,
                                                input logic src_b, input logic ext,
                                                input logic md);
        return {op, src_a, src_b, ext, md};
    endfunction

    function automatic logic [MEM_W-1:0] mem_pack(input load_e ld, input store_e st);
        return {st, ld, (st != ST_NONE), (ld != LD_NONE)};
    endfunction

    function automatic logic [WB_W-1:0] wb_pack(input logic we, input mtr_e mtr);
        return {mtr, we};
    endfunction

    function automatic alu_op_e r_alu_op(input logic [5:0] fn);
        case (fn)
            FN_SUB, FN_SUBU: return ALU_SUB;
            FN_AND:          return ALU_AND;
            FN_OR:           return ALU_OR;
            FN_XOR:          return ALU_XOR;
            FN_NOR:          return ALU_NOR;
            FN_SLT:          return ALU_SLT;
            FN_SLTU:         return ALU_SLTU;
            FN_SLL:          return ALU_SLL;
            FN_SRL:          return ALU_SRL;
            FN_SRA:          return ALU_SRA;
            default:         return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/pipe_ctrl_hazard_unit_decode.sv
// Combinational ID-stage decoder: instruction word -> EX/MEM/WB bundles,
// destination register, source-register usage and branch class.
module pipe_ctrl_hazard_unit_decode
    import pipe_ctrl_hazard_unit_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic [31:0]       instr,
    input  logic              valid,
    output dec_t              dec,
    output logic [REG_AW-1:0] wa,
    output logic [REG_AW-1:0] rs,
    output logic [REG_AW-1:0] rt
);

    logic [5:0] opcode;
    logic [5:0] func;
    logic [4:0] f_rs;
    logic [4:0] f_rt;
    logic [4:0] f_rd;
    logic [4:0] wa_sel;

    assign opcode = instr[31:26];
    assign f_rs   = instr[25:21];
    assign f_rt   = instr[20:16];
    assign f_rd   = instr[15:11];
    assign func   = instr[5:0];

    // Source fields are reported only when actually read, so an unused field
    // can never raise a false hazard or forwarding select downstream.
    assign wa = REG_AW'(wa_sel);
    assign rs = dec.reads_rs ? REG_AW'(f_rs) : '0;
    assign rt = dec.reads_rt ? REG_AW'(f_rt) : '0;

    // Decode table; invalid slots and the all-zero nop decode as a bubble
    always_comb begin
        dec    = DEC_BUBBLE;
        wa_sel = '0;
        if (valid && (instr != 32'd0)) begin
            case (opcode)
                OP_RTYPE: begin
                    case (func)
                        FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR,
                        FN_XOR, FN_NOR, FN_SLT, FN_SLTU: begin
                            dec.ex       = ex_pack(r_alu_op(func), 1'b0, 1'b0, 1'b0, 1'b0);
                            dec.wb       = wb_pack(1'b1, MTR_ALU);
                            dec.reads_rs = 1'b1;
                            dec.reads_rt = 1'b1;
                            wa_sel       = f_rd;
                        end
                        FN_SLL, FN_SRL, FN_SRA: begin
                            dec.ex       = ex_pack(r_alu_op(func), 1'b1, 1'b0, 1'b0, 1'b0);
                            dec.wb       = wb_pack(1'b1, MTR_ALU);
                            dec.reads_rt = 1'b1;
                            wa_sel       = f_rd;
                        end
                        FN_JR: begin
                            dec.reads_rs = 1'b1;
                            dec.br       = BR_JR;
                        end
                        FN_JALR: begin
                            dec.reads_rs = 1'b1;
                            dec.br       = BR_JR;
                            dec.wb       = wb_pack(1'b1, MTR_LINK);
                            wa_sel       = f_rd;
                        end
                        FN_MFHI, FN_MFLO: begin
                            dec.ex   = ex_pack((func == FN_MFHI) ? ALU_HI : ALU_LO,
                                               1'b0, 1'b0, 1'b0, 1'b0);
                            dec.wb   = wb_pack(1'b1, MTR_HILO);
                            dec.hilo = 1'b1;
                            wa_sel   = f_rd;
                        end
                        FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: begin
                            dec.ex       = ex_pack((func == FN_MULT || func == FN_MULTU) ? ALU_MULT : ALU_DIV,
                                                   1'b0, 1'b0,
                                                   (func == FN_MULT || func == FN_DIV), 1'b1);
                            dec.reads_rs = 1'b1;
                            dec.reads_rt = 1'b1;
                            dec.hilo     = 1'b1;
                        end
                        default: ;
                    endcase
                end
                OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI: begin
                    case (opcode)
                        OP_SLTI:  dec.ex = ex_pack(ALU_SLT,  1'b0, 1'b1, 1'b1, 1'b0);
                        OP_SLTIU: dec.ex = ex_pack(ALU_SLTU, 1'b0, 1'b1, 1'b1, 1'b0);
                        OP_ANDI:  dec.ex = ex_pack(ALU_AND,  1'b0, 1'b1, 1'b0, 1'b0);
                        OP_ORI:   dec.ex = ex_pack(ALU_OR,   1'b0, 1'b1, 1'b0, 1'b0);
                        OP_XORI:  dec.ex = ex_pack(ALU_XOR,  1'b0, 1'b1, 1'b0, 1'b0);
                        default:  dec.ex = ex_pack(ALU_ADD,  1'b0, 1'b1, 1'b1, 1'b0);
                    endcase
                    dec.wb       = wb_pack(1'b1, MTR_ALU);
                    dec.reads_rs = 1'b1;
                    wa_sel       = f_rt;
                end
                OP_LUI: begin
                    dec.ex = ex_pack(ALU_LUI, 1'b0, 1'b1, 1'b0, 1'b0);
                    dec.wb = wb_pack(1'b1, MTR_ALU);
                    wa_sel = f_rt;
                end
                OP_LW, OP_LB, OP_LBU: begin
                    dec.ex       = ex_pack(ALU_ADD, 1'b0, 1'b1, 1'b1, 1'b0);
                    dec.mem      = mem_pack((opcode == OP_LW) ? LD_W :
                                            (opcode == OP_LB) ? LD_B : LD_BU, ST_NONE);
                    dec.wb       = wb_pack(1'b1, MTR_MEM);
                    dec.reads_rs = 1'b1;
                    wa_sel       = f_rt;
                end
                OP_SW, OP_SB: begin
                    dec.ex       = ex_pack(ALU_ADD, 1'b0, 1'b1, 1'b1, 1'b0);
                    dec.mem      = mem_pack(LD_NONE, (opcode == OP_SW) ? ST_W : ST_B);
                    dec.reads_rs = 1'b1;
                    dec.reads_rt = 1'b1;
                end
                OP_BEQ, OP_BNE: begin
                    dec.br       = (opcode == OP_BEQ) ? BR_BEQ : BR_BNE;
                    dec.reads_rs = 1'b1;
                    dec.reads_rt = 1'b1;
                end
                OP_BLEZ, OP_BGTZ: begin
                    dec.br       = (opcode == OP_BLEZ) ? BR_BLEZ : BR_BGTZ;
                    dec.reads_rs = 1'b1;
                end
                OP_REGIMM: begin
                    if (f_rt == RT_BLTZ) begin
                        dec.br       = BR_BLTZ;
                        dec.reads_rs = 1'b1;
                    end else if (f_rt == RT_BGEZ) begin
                        dec.br       = BR_BGEZ;
                        dec.reads_rs = 1'b1;
                    end
                end
                OP_J: begin
                    dec.br = BR_J;
                end
                OP_JAL: begin
                    dec.br = BR_J;
                    dec.wb = wb_pack(1'b1, MTR_LINK);
                    wa_sel = 5'd31;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/pipe_ctrl_hazard_unit.sv
// 5-stage pipeline controller: ID decode, EX/MEM/WB control registers,
// load-use / branch / HI-LO interlocks, EX forwarding and redirect select.
module pipe_ctrl_hazard_unit
    import pipe_ctrl_hazard_unit_pkg::*;
#(
    parameter int MULDIV_LAT        = 4,    // 1..15
    parameter bit BRANCH_DELAY_SLOT = 1'b1,
    parameter int REG_AW            = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       instr_id,
    input  logic              id_valid,
    input  logic [1:0]        rs_cmp_rt,
    input  logic [1:0]        rs_cmp_z,
    output logic              stall_if_id,
    output logic              flush_if_id,
    output logic [1:0]        pc_src,
    output logic [EX_W-1:0]   ex_ctrl,
    output logic [MEM_W-1:0]  mem_ctrl,
    output logic [WB_W-1:0]   wb_ctrl,
    output logic [REG_AW-1:0] ex_wa,
    output logic [REG_AW-1:0] mem_wa,
    output logic [REG_AW-1:0] wb_wa,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              muldiv_busy
);

    localparam int              CNT_W   = 4;
    localparam logic [CNT_W-1:0] MD_LOAD = CNT_W'(MULDIV_LAT);

    dec_t              id_dec;
    logic [REG_AW-1:0] id_wa;
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;

    logic [MEM_W-1:0]  ex_mem_q;
    logic [WB_W-1:0]   ex_wb_q;
    logic [REG_AW-1:0] ex_rs_q;
    logic [REG_AW-1:0] ex_rt_q;
    logic [WB_W-1:0]   mem_wb_q;
    logic [CNT_W-1:0]  md_cnt;

    logic ex_hit;
    logic mem_hit;
    logic load_use;
    logic br_src;
    logic br_haz;
    logic md_haz;
    logic taken;

    pipe_ctrl_hazard_unit_decode #(.REG_AW(REG_AW)) u_decode (
        .instr (instr_id),
        .valid (id_valid),
        .dec   (id_dec),
        .wa    (id_wa),
        .rs    (id_rs),
        .rt    (id_rt)
    );

    assign muldiv_busy = (md_cnt != '0);

    // Interlock detection; id_rs/id_rt are already zero when not read
    always_comb begin
        ex_hit   = (ex_wa != '0) && ((ex_wa == id_rs) || (ex_wa == id_rt));
        mem_hit  = (mem_wa != '0) && ((mem_wa == id_rs) || (mem_wa == id_rt));
        load_use = ex_mem_q[MEM_RD_BIT] && ex_hit;
        br_src   = (id_dec.br != BR_NONE) && (id_dec.br != BR_J);
        br_haz   = br_src && ((ex_wb_q[WB_REGWRE_BIT] && ex_hit) ||
                              (mem_ctrl[MEM_RD_BIT] && mem_hit));
        md_haz   = id_dec.hilo && (muldiv_busy || ex_ctrl[EX_MULDIV_BIT]);
        stall_if_id = !rst && (load_use || br_haz || md_haz);
    end

    // Redirect select; a stall always suppresses the redirect
    always_comb begin
        taken = 1'b0;
        case (id_dec.br)
            BR_BEQ:  taken = (rs_cmp_rt == 2'b01);
            BR_BNE:  taken = (rs_cmp_rt != 2'b01);
            BR_BLEZ: taken = (rs_cmp_z == 2'b00) || (rs_cmp_z == 2'b01);
            BR_BGTZ: taken = (rs_cmp_z == 2'b10);
            BR_BLTZ: taken = (rs_cmp_z == 2'b00);
            BR_BGEZ: taken = (rs_cmp_z == 2'b01) || (rs_cmp_z == 2'b10);
            default: taken = 1'b0;
        endcase
        pc_src = 2'b00;
        if (!rst && !stall_if_id) begin
            case (id_dec.br)
                BR_J:    pc_src = 2'b10;
                BR_JR:   pc_src = 2'b11;
                default: pc_src = taken ? 2'b01 : 2'b00;
            endcase
        end
        flush_if_id = (BRANCH_DELAY_SLOT == 1'b0) && (pc_src != 2'b00);
    end

    // EX operand forwarding; MEM wins over WB, $0 never forwarded
    always_comb begin
        fwd_a = 2'b00;
        fwd_b = 2'b00;
        if (!rst) begin
            if (mem_wb_q[WB_REGWRE_BIT] && (mem_wa != '0) && (mem_wa == ex_rs_q))
                fwd_a = 2'b10;
            else if (wb_ctrl[WB_REGWRE_BIT] && (wb_wa != '0) && (wb_wa == ex_rs_q))
                fwd_a = 2'b01;
            if (mem_wb_q[WB_REGWRE_BIT] && (mem_wa != '0) && (mem_wa == ex_rt_q))
                fwd_b = 2'b10;
            else if (wb_ctrl[WB_REGWRE_BIT] && (wb_wa != '0) && (wb_wa == ex_rt_q))
                fwd_b = 2'b01;
        end
    end

    // ID->EX->MEM->WB control shift; ID/EX takes a bubble while stalled
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_ctrl  <= EX_BUBBLE;
            ex_mem_q <= MEM_BUBBLE;
            ex_wb_q  <= WB_BUBBLE;
            ex_wa    <= '0;
            ex_rs_q  <= '0;
            ex_rt_q  <= '0;
            mem_ctrl <= MEM_BUBBLE;
            mem_wb_q <= WB_BUBBLE;
            mem_wa   <= '0;
            wb_ctrl  <= WB_BUBBLE;
            wb_wa    <= '0;
        end else begin
            if (stall_if_id) begin
                ex_ctrl  <= EX_BUBBLE;
                ex_mem_q <= MEM_BUBBLE;
                ex_wb_q  <= WB_BUBBLE;
                ex_wa    <= '0;
                ex_rs_q  <= '0;
                ex_rt_q  <= '0;
            end else begin
                ex_ctrl  <= id_dec.ex;
                ex_mem_q <= id_dec.mem;
                ex_wb_q  <= id_dec.wb;
                ex_wa    <= id_wa;
                ex_rs_q  <= id_rs;
                ex_rt_q  <= id_rt;
            end
            mem_ctrl <= ex_mem_q;
            mem_wb_q <= ex_wb_q;
            mem_wa   <= ex_wa;
            wb_ctrl  <= mem_wb_q;
            wb_wa    <= mem_wa;
        end
    end

    // HI/LO occupancy down-counter, reloaded as a mult/div leaves EX
    always_ff @(posedge clk) begin
        if (rst)
            md_cnt <= '0;
        else if (ex_ctrl[EX_MULDIV_BIT])
            md_cnt <= MD_LOAD;
        else if (md_cnt != '0)
            md_cnt <= md_cnt - 1'b1;
    end

endmodule

// File: tb/tb_pipe_ctrl_hazard_unit.sv
// Directed bench for pipe_ctrl_hazard_unit; a second instance without the
// delay slot shares the stimulus so the flush behaviour is observable.
module tb_pipe_ctrl_hazard_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr_id;
    logic        id_valid;
    logic [1:0]  rs_cmp_rt;
    logic [1:0]  rs_cmp_z;

    logic       stall_if_id, flush_if_id, muldiv_busy;
    logic [1:0] pc_src, fwd_a, fwd_b;
    logic [7:0] ex_ctrl;
    logic [5:0] mem_ctrl;
    logic [2:0] wb_ctrl;
    logic [4:0] ex_wa, mem_wa, wb_wa;

    logic       stall_n, flush_n, busy_n;
    logic [1:0] pc_src_n, fwd_a_n, fwd_b_n;
    logic [7:0] ex_ctrl_n;
    logic [5:0] mem_ctrl_n;
    logic [2:0] wb_ctrl_n;
    logic [4:0] ex_wa_n, mem_wa_n, wb_wa_n;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pipe_ctrl_hazard_unit #(.MULDIV_LAT(4), .BRANCH_DELAY_SLOT(1'b1), .REG_AW(5)) dut (
        .clk(clk), .rst(rst), .instr_id(instr_id), .id_valid(id_valid),
        .rs_cmp_rt(rs_cmp_rt), .rs_cmp_z(rs_cmp_z),
        .stall_if_id(stall_if_id), .flush_if_id(flush_if_id), .pc_src(pc_src),
        .ex_ctrl(ex_ctrl), .mem_ctrl(mem_ctrl), .wb_ctrl(wb_ctrl),
        .ex_wa(ex_wa), .mem_wa(mem_wa), .wb_wa(wb_wa),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .muldiv_busy(muldiv_busy)
    );

    pipe_ctrl_hazard_unit #(.MULDIV_LAT(4), .BRANCH_DELAY_SLOT(1'b0), .REG_AW(5)) dut_n (
        .clk(clk), .rst(rst), .instr_id(instr_id), .id_valid(id_valid),
        .rs_cmp_rt(rs_cmp_rt), .rs_cmp_z(rs_cmp_z),
        .stall_if_id(stall_n), .flush_if_id(flush_n), .pc_src(pc_src_n),
        .ex_ctrl(ex_ctrl_n), .mem_ctrl(mem_ctrl_n), .wb_ctrl(wb_ctrl_n),
        .ex_wa(ex_wa_n), .mem_wa(mem_wa_n), .wb_wa(wb_wa_n),
        .fwd_a(fwd_a_n), .fwd_b(fwd_b_n), .muldiv_busy(busy_n)
    );

    function automatic logic [31:0] enc_r(input logic [5:0] fn, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [4:0] rd);
        return {6'h00, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] ins, input logic v);
        instr_id = ins;
        id_valid = v;
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        instr_id  = 32'd0;
        id_valid  = 1'b0;
        rs_cmp_rt = 2'b00;
        rs_cmp_z  = 2'b00;
        tick();
        tick();

        // Reset state, and redirect suppressed while in reset
        chk("rst_ex_ctrl", ex_ctrl, 0);
        chk("rst_mem_ctrl", mem_ctrl, 0);
        chk("rst_wb_ctrl", wb_ctrl, 0);
        chk("rst_wa", {ex_wa, mem_wa, wb_wa}, 0);
        chk("rst_busy", muldiv_busy, 0);
        chk("rst_fwd", {fwd_a, fwd_b}, 0);
        drive(enc_i(6'h02, 5'd0, 5'd0, 16'h0010), 1'b1);
        chk("rst_pc_src", pc_src, 0);
        chk("rst_flush_n", flush_n, 0);
        chk("rst_stall", stall_if_id, 0);
        rst = 1'b0;
        drive(32'd0, 1'b0);
        tick();

        // Load-use: lw $2,0($1) ; add $3,$2,$4
        drive(enc_i(6'h23, 5'd1, 5'd2, 16'h0000), 1'b1);
        chk("lw_no_stall", stall_if_id, 0);
        tick();
        drive(enc_r(6'h20, 5'd2, 5'd4, 5'd3), 1'b1);
        chk("lu_stall", stall_if_id, 1);
        chk("lu_pc_src", pc_src, 0);
        tick();
        chk("lu_bubble", ex_ctrl, 0);
        chk("lu_bubble_wa", ex_wa, 0);
        chk("lu_release", stall_if_id, 0);
        chk("lu_mem_ctrl", mem_ctrl, 6'h05);
        tick();
        chk("lu_fwd_a", fwd_a, 2'b01);
        chk("lu_fwd_b", fwd_b, 2'b00);
        chk("lu_wb_ctrl", wb_ctrl, 3'h3);
        chk("lu_wb_wa", wb_wa, 2);

        // Back-to-back ALU: add $5,$1,$1 ; sub $6,$5,$5
        drive(enc_r(6'h20, 5'd1, 5'd1, 5'd5), 1'b1);
        tick();
        drive(enc_r(6'h22, 5'd5, 5'd5, 5'd6), 1'b1);
        chk("alu_no_stall", stall_if_id, 0);
        tick();
        chk("alu_fwd", {fwd_a, fwd_b}, 4'b1010);
        chk("alu_ex_ctrl", ex_ctrl, 8'h10);
        chk("alu_ex_wa", ex_wa, 6);

        // $0 destination: add $0,$1,$1 ; or $7,$0,$0
        drive(enc_r(6'h20, 5'd1, 5'd1, 5'd0), 1'b1);
        tick();
        drive(enc_r(6'h25, 5'd0, 5'd0, 5'd7), 1'b1);
        tick();
        chk("r0_fwd", {fwd_a, fwd_b}, 4'b0000);
        chk("r0_ex_wa", ex_wa, 7);

        // MEM over WB: add $8,$1,$1 ; add $8,$2,$2 ; sub $9,$8,$8
        drive(enc_r(6'h20, 5'd1, 5'd1, 5'd8), 1'b1);
        tick();
        drive(enc_r(6'h20, 5'd2, 5'd2, 5'd8), 1'b1);
        tick();
        drive(enc_r(6'h22, 5'd8, 5'd8, 5'd9), 1'b1);
        tick();
        chk("prio_fwd", {fwd_a, fwd_b}, 4'b1010);

        // Branch conditions, evaluated combinationally in ID
        drive(enc_i(6'h04, 5'd1, 5'd2, 16'h0004), 1'b1);
        rs_cmp_rt = 2'b01; #1;
        chk("beq_taken", pc_src, 2'b01);
        chk("beq_flush_ds", flush_if_id, 0);
        chk("beq_flush_n", flush_n, 1);
        rs_cmp_rt = 2'b00; #1;
        chk("beq_not_taken", pc_src, 2'b00);
        chk("beq_nt_flush_n", flush_n, 0);
        drive(enc_i(6'h05, 5'd1, 5'd2, 16'h0004), 1'b1);
        chk("bne_taken", pc_src, 2'b01);
        rs_cmp_rt = 2'b01; #1;
        chk("bne_not_taken", pc_src, 2'b00);
        drive(enc_i(6'h06, 5'd1, 5'd0, 16'h0004), 1'b1);
        rs_cmp_z = 2'b10; #1;
        chk("blez_gt", pc_src, 2'b00);
        rs_cmp_z = 2'b01; #1;
        chk("blez_eq", pc_src, 2'b01);
        drive(enc_i(6'h07, 5'd1, 5'd0, 16'h0004), 1'b1);
        chk("bgtz_eq", pc_src, 2'b00);
        rs_cmp_z = 2'b10; #1;
        chk("bgtz_gt", pc_src, 2'b01);
        drive(enc_i(6'h01, 5'd1, 5'd0, 16'h0004), 1'b1);
        chk("bltz_gt", pc_src, 2'b00);
        rs_cmp_z = 2'b00; #1;
        chk("bltz_lt", pc_src, 2'b01);
        drive(enc_i(6'h01, 5'd1, 5'd1, 16'h0004), 1'b1);
        chk("bgez_lt", pc_src, 2'b00);
        rs_cmp_z = 2'b01; #1;
        chk("bgez_eq", pc_src, 2'b01);
        drive(enc_i(6'h02, 5'd0, 5'd0, 16'h0040), 1'b1);
        chk("j_pc_src", pc_src, 2'b10);
        chk("j_flush_n", flush_n, 1);
        drive(enc_i(6'h02, 5'd0, 5'd0, 16'h0040), 1'b0);
        chk("invalid_pc_src", pc_src, 2'b00);

        // jal writes $31
        drive(enc_i(6'h03, 5'd0, 5'd0, 16'h0040), 1'b1);
        tick();
        chk("jal_ex_wa", ex_wa, 31);
        chk("jal_wb_bundle", {ex_ctrl, mem_ctrl}, 0);

        // addi $3,$0,5 ; jr $3 -> one stall, then pc_src=11
        drive(enc_i(6'h08, 5'd0, 5'd3, 16'h0005), 1'b1);
        tick();
        drive(enc_r(6'h08, 5'd3, 5'd0, 5'd0), 1'b1);
        chk("jr_stall", stall_if_id, 1);
        chk("jr_stall_pc_src", pc_src, 2'b00);
        chk("jr_stall_flush_n", flush_n, 0);
        tick();
        chk("jr_release", stall_if_id, 0);
        chk("jr_pc_src", pc_src, 2'b11);
        chk("jr_flush_ds", flush_if_id, 0);
        chk("jr_flush_n", flush_n, 1);
        tick();

        // mult $1,$2 ; mflo $10 held until the HI/LO unit is free
        drive(enc_r(6'h18, 5'd1, 5'd2, 5'd0), 1'b1);
        chk("mult_no_stall", stall_if_id, 0);
        tick();
        chk("mult_ex_ctrl", ex_ctrl, 8'hE3);
        drive(enc_r(6'h12, 5'd0, 5'd0, 5'd10), 1'b1);
        chk("md_ex_stall", stall_if_id, 1);
        chk("md_ex_busy", muldiv_busy, 0);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("md_busy", muldiv_busy, 1);
            chk("md_hold", stall_if_id, 1);
            chk("md_bubble", ex_ctrl, 0);
        end
        tick();
        chk("md_free", muldiv_busy, 0);
        chk("md_release", stall_if_id, 0);
        tick();
        chk("mflo_ex_ctrl", ex_ctrl, 8'hD0);
        chk("mflo_ex_wa", ex_wa, 10);

        // Reset two cycles into a mult
        drive(enc_r(6'h18, 5'd1, 5'd2, 5'd0), 1'b1);
        chk("mult2_no_stall", stall_if_id, 0);
        tick();
        drive(32'd0, 1'b0);
        tick();
        chk("mult2_busy", muldiv_busy, 1);
        rst = 1'b1;
        drive(enc_i(6'h02, 5'd0, 5'd0, 16'h0040), 1'b1);
        chk("rst_mid_pc_src_now", pc_src, 2'b00);
        tick();
        chk("rst_mid_busy", muldiv_busy, 0);
        chk("rst_mid_bundles", {ex_ctrl, mem_ctrl, wb_ctrl}, 0);
        chk("rst_mid_wa", {ex_wa, mem_wa, wb_wa}, 0);
        chk("rst_mid_fwd", {fwd_a, fwd_b}, 0);
        chk("rst_mid_pc_src", pc_src, 2'b00);
        chk("rst_mid_stall", stall_if_id, 0);
        chk("rst_mid_flush_n", flush_n, 0);
        rst = 1'b0;
        drive(32'd0, 1'b0);
        tick();
        tick();
        chk("post_rst_busy", muldiv_busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
